noc_rr_lock_arbiter: RTL and testbench

//   N-way round-robin arbiter with packet (wormhole) locking, for router output-port allocation.

---
 rtl/noc_rr_lock_arbiter.sv | 98 +++++++++
 tb/tb_noc_rr_lock_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/noc_rr_lock_arbiter.sv
// Round-robin output-port arbiter with optional wormhole locking: once a multi-flit packet
// wins, the output stays with that input until its tail flit is accepted.
module noc_rr_lock_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  bit LOCK_EN = 1'b1,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               locked
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] one_hot;
    logic               transfer;
    int                 cand;

    // Winner selection: the owner alone while locked, otherwise the first requester at or after ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        if (state_q == S_LOCKED) begin
            win_found = req[owner_q];
            win_idx   = owner_q;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = int'(ptr_q) + k;
                if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                if (!win_found && req[cand]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(cand);
                end
            end
        end
        // Outputs must read zero for the whole time reset is held, not just after the next edge.
        if (reset) win_found = 1'b0;
    end

    always_comb begin
        one_hot          = '0;
        one_hot[win_idx] = win_found;
    end

    assign grant       = one_hot;
    assign grant_valid = win_found;
    assign grant_idx   = win_found ? win_idx : '0;
    assign locked      = LOCK_EN && (state_q == S_LOCKED) && !reset;
    assign transfer    = accept && win_found;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (transfer) begin
            ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
            if (state_q == S_IDLE) begin
                if (LOCK_EN && !last[win_idx]) begin
                    state_d = S_LOCKED;
                    owner_d = win_idx;
                end
            end else if (last[owner_q]) begin
                state_d = S_IDLE;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments and reset asynchronously on reset's rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_noc_rr_lock_arbiter.sv
// Scoreboard bench: the driver queues the expected outputs for each cycle it drives, and a
// monitor on the falling edge pops and compares them against a 4-way locking and 5-way unlocked arbiter.
module tb_noc_rr_lock_arbiter;

    logic clk = 1'b0;
    logic reset;

    logic [3:0] req_a, last_a, grant_a;
    logic       accept_a, grant_valid_a, locked_a;
    logic [1:0] grant_idx_a;

    logic [4:0] req_b, last_b, grant_b;
    logic       accept_b, grant_valid_b, locked_b;
    logic [2:0] grant_idx_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         dut;
        logic [4:0] grant;
        logic [2:0] idx;
        logic       locked;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    noc_rr_lock_arbiter #(.NUM_REQ(4), .LOCK_EN(1'b1)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .req        (req_a),
        .last       (last_a),
        .accept     (accept_a),
        .grant      (grant_a),
        .grant_valid(grant_valid_a),
        .grant_idx  (grant_idx_a),
        .locked     (locked_a)
    );

    noc_rr_lock_arbiter #(.NUM_REQ(5), .LOCK_EN(1'b0)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .req        (req_b),
        .last       (last_b),
        .accept     (accept_b),
        .grant      (grant_b),
        .grant_valid(grant_valid_b),
        .grant_idx  (grant_idx_b),
        .locked     (locked_b)
    );

    task automatic check(input string name, input string field,
                         input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %b expected %b", name, field, act, exp);
        end
    endtask

    // Monitor: one queued expectation per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.dut == 0) begin
                check(e.name, "grant",       8'(grant_a),       8'(e.grant));
                check(e.name, "grant_valid", 8'(grant_valid_a), 8'(|e.grant));
                check(e.name, "grant_idx",   8'(grant_idx_a),   8'(e.idx));
                check(e.name, "locked",      8'(locked_a),      8'(e.locked));
            end else begin
                check(e.name, "grant",       8'(grant_b),       8'(e.grant));
                check(e.name, "grant_valid", 8'(grant_valid_b), 8'(|e.grant));
                check(e.name, "grant_idx",   8'(grant_idx_b),   8'(e.idx));
                check(e.name, "locked",      8'(locked_b),      8'(e.locked));
            end
        end
    end

    task automatic step(input int dut, input logic rst,
                        input logic [4:0] rq, input logic [4:0] lst, input logic acc,
                        input logic [4:0] eg, input logic [2:0] ei, input logic el,
                        input string nm);
        exp_t e;
        reset = rst;
        if (dut == 0) begin
            req_a = rq[3:0]; last_a = lst[3:0]; accept_a = acc;
            req_b = '0;      last_b = '0;       accept_b = 1'b0;
        end else begin
            req_b = rq;      last_b = lst;      accept_b = acc;
            req_a = '0;      last_a = '0;       accept_a = 1'b0;
        end
        e.dut = dut; e.grant = eg; e.idx = ei; e.locked = el; e.name = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req_a = '0; last_a = '0; accept_a = 1'b0;
        req_b = '0; last_b = '0; accept_b = 1'b0;
        @(posedge clk);
        #1;

        // Held in reset with requests present: outputs forced to zero.
        step(0, 1, 5'b01111, 5'b01111, 1, 5'b00000, 0, 0, "rst_hold");

        // 1: full request, single-flit packets, rotation 0,1,2,3,0.
        step(0, 0, 5'b01111, 5'b01111, 1, 5'b00001, 0, 0, "rr0");
        step(0, 0, 5'b01111, 5'b01111, 1, 5'b00010, 1, 0, "rr1");
        step(0, 0, 5'b01111, 5'b01111, 1, 5'b00100, 2, 0, "rr2");
        step(0, 0, 5'b01111, 5'b01111, 1, 5'b01000, 3, 0, "rr3");
        step(0, 0, 5'b01111, 5'b01111, 1, 5'b00001, 0, 0, "rr_wrap");

        // 2: pointer only moves on accept.
        step(0, 1, 5'b00000, 5'b00000, 0, 5'b00000, 0, 0, "rst2");
        step(0, 0, 5'b00101, 5'b01111, 0, 5'b00001, 0, 0, "hold_a");
        step(0, 0, 5'b00101, 5'b01111, 0, 5'b00001, 0, 0, "hold_b");
        step(0, 0, 5'b00101, 5'b01111, 0, 5'b00001, 0, 0, "hold_c");
        step(0, 0, 5'b00101, 5'b01111, 1, 5'b00001, 0, 0, "hold_acc");
        step(0, 0, 5'b00101, 5'b01111, 0, 5'b00100, 2, 0, "after_acc");

        // 3: three-flit packet on input 0 while input 1 waits.
        step(0, 1, 5'b00000, 5'b00000, 0, 5'b00000, 0, 0, "rst3");
        step(0, 0, 5'b00011, 5'b00000, 1, 5'b00001, 0, 0, "pkt_head");
        step(0, 0, 5'b00011, 5'b00000, 1, 5'b00001, 0, 1, "pkt_body");
        step(0, 0, 5'b00011, 5'b00001, 1, 5'b00001, 0, 1, "pkt_tail");
        step(0, 0, 5'b00010, 5'b00010, 1, 5'b00010, 1, 0, "pkt_next");
        // No request with accept high: pointer (now 2) must hold.
        step(0, 0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, "idle_acc");
        step(0, 0, 5'b01111, 5'b01111, 0, 5'b00100, 2, 0, "ptr_held");

        // 4: owner drops req mid-packet; nobody else may take the output.
        step(0, 1, 5'b00000, 5'b00000, 0, 5'b00000, 0, 0, "rst4");
        step(0, 0, 5'b00101, 5'b00000, 1, 5'b00001, 0, 0, "own_head");
        step(0, 0, 5'b00100, 5'b00000, 1, 5'b00000, 0, 1, "own_gap1");
        step(0, 0, 5'b00100, 5'b00000, 1, 5'b00000, 0, 1, "own_gap2");
        step(0, 0, 5'b00101, 5'b00001, 1, 5'b00001, 0, 1, "own_tail");
        step(0, 0, 5'b00100, 5'b00100, 0, 5'b00100, 2, 0, "own_after");

        // 6: lock on input 2, then reset mid-packet.
        step(0, 0, 5'b00100, 5'b00000, 1, 5'b00100, 2, 0, "lk2_head");
        step(0, 0, 5'b00100, 5'b00000, 0, 5'b00100, 2, 1, "lk2_body");
        step(0, 1, 5'b01111, 5'b00000, 0, 5'b00000, 0, 0, "rst_locked");
        step(0, 0, 5'b01111, 5'b01111, 0, 5'b00001, 0, 0, "post_rst");

        // 5: 5-way, lock disabled, pointer started at 4, alternation with wrap.
        step(1, 0, 5'b01000, 5'b00000, 1, 5'b01000, 3, 0, "b_seed");
        step(1, 0, 5'b10001, 5'b00000, 1, 5'b10000, 4, 0, "b_alt0");
        step(1, 0, 5'b10001, 5'b00000, 1, 5'b00001, 0, 0, "b_alt1");
        step(1, 0, 5'b10001, 5'b00000, 1, 5'b10000, 4, 0, "b_alt2");
        step(1, 0, 5'b10001, 5'b00000, 1, 5'b00001, 0, 0, "b_alt3");

        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
